// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, size masks,
// FSM state encoding and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Data-memory port of the load/store sequencer.
// Handshake: the master raises mem_req with mem_addr/mem_we/mem_wstrb/mem_wdata
// and holds them stable until a cycle in which the slave drives mem_ack high;
// that cycle completes the transfer and mem_rdata is valid in it. mem_ack while
// mem_req is low has no effect.
interface load_store_sequencer_if #(
  parameter int XLEN = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/strobe placement across two words,
// split detection and load merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        split,
  output logic [31:0] load_ext
);

  logic [31:0] merged;

  assign wdata  = {32'b0, store_data} << {off, 3'b000};
  assign wstrb  = {4'b0, size_mask(funct3[1:0])} << off;
  assign split  = ({1'b0, off} + size_bytes(funct3[1:0])) > 3'd4;
  // hi is zero for non-split accesses, so the shift only pulls in zeros.
  assign merged = 32'({hi, lo} >> {off, 3'b000});

  always_comb begin
    load_ext = merged;
    case (funct3)
      F3_B:    load_ext = {{24{merged[7]}}, merged[7:0]};
      F3_H:    load_ext = {{16{merged[15]}}, merged[15:0]};
      F3_BU:   load_ext = {24'b0, merged[7:0]};
      F3_HU:   load_ext = {16'b0, merged[15:0]};
      default: load_ext = merged;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: latches one request, issues one or two aligned word
// transactions on the memory port and returns the extended load result.
module load_store_sequencer
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_load,
  input  logic [2:0]              funct3,
  input  logic [XLEN-1:0]         address,
  input  logic [XLEN-1:0]         store_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [XLEN-1:0]         load_data,
  output lsu_state_t              state_dbg,
  load_store_sequencer_if.master  mem
);

  lsu_state_t  state, state_next;
  logic        op_load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] lo_q;
  logic        error_q;

  logic [63:0] wdata64;
  logic [7:0]  wstrb8;
  logic        split;
  logic [31:0] load_ext;
  logic [31:0] lo_in;
  logic [31:0] hi_in;

  // Feed the ack-cycle read word straight in so load_data is ready with done.
  assign lo_in = (state == ACC0) ? mem.mem_rdata : lo_q;
  assign hi_in = (state == ACC1) ? mem.mem_rdata : 32'b0;

  lsu_align u_align (
    .off        (addr_q[1:0]),
    .funct3     (funct3_q),
    .store_data (sdata_q),
    .lo         (lo_in),
    .hi         (hi_in),
    .wdata      (wdata64),
    .wstrb      (wstrb8),
    .split      (split),
    .load_ext   (load_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = is_legal(op_load, funct3) ? ACC0 : DONE;
      ACC0: if (mem.mem_ack) state_next = split ? ACC1 : DONE;
      ACC1: if (mem.mem_ack) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_load_q <= 1'b0;
      funct3_q  <= 3'b0;
      addr_q    <= 32'b0;
      sdata_q   <= 32'b0;
      lo_q      <= 32'b0;
      error_q   <= 1'b0;
      load_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_load_q <= op_load;
        funct3_q  <= funct3;
        addr_q    <= address;
        sdata_q   <= store_data;
        error_q   <= !is_legal(op_load, funct3);
      end
      if (state == ACC0 && mem.mem_ack && op_load_q)
        lo_q <= mem.mem_rdata;
      if (state == IDLE && start && !is_legal(op_load, funct3))
        load_data <= '0;
      else if (op_load_q && mem.mem_ack &&
               ((state == ACC0 && !split) || state == ACC1))
        load_data <= load_ext;
    end
  end

  // Memory-side outputs decode from state and latched fields only.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wstrb = '0;
    mem.mem_wdata = '0;
    case (state)
      ACC0: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = !op_load_q;
        mem.mem_addr = {addr_q[31:2], 2'b00};
        if (!op_load_q) begin
          mem.mem_wstrb = wstrb8[3:0];
          mem.mem_wdata = wdata64[31:0];
        end
      end
      ACC1: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = !op_load_q;
        mem.mem_addr = {addr_q[31:2] + 30'd1, 2'b00};
        if (!op_load_q) begin
          mem.mem_wstrb = wstrb8[7:4];
          mem.mem_wdata = wdata64[63:32];
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign error     = (state == DONE) && error_q;
  assign state_dbg = state;

endmodule
